mesh_load_ctrl: RTL

- Sequences loading of one mesh object from the SPI slave word stream into the shared 32-bit quad-RAM, then launches the subdivision engine and tracks it to completion.
- Parses the stream layout: vertex_count, 3*V vertex words, face_count, 3*F face words, one trailer word.
- Generates RAM write address, data and strobe, and bounds-checks the object against RAM size.
- Sits between the SPI slave and the RAM/subsurf core inside top.

---
 rtl/mesh_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mesh_load_ctrl.sv
// -----------------------------------------------------------------------------
// mesh_load_ctrl
//
// Sequences loading of one mesh object from the SPI slave word stream into the
// shared quad-RAM, then launches the subdivision core and tracks it until it
// finishes.
//
// Stream layout: vertex_count (V), 3*V vertex words, face_count (F),
// 3*F face words, one trailer word. Every word except the trailer is written
// to RAM at consecutive addresses starting at 0. An object must satisfy
// 3*(V+F)+2 <= 2**ADDR_WIDTH with V and F both non-zero.
//
// Configuration macro:
//   MESH_CHECKSUM_EN  when defined, a 32-bit wrapping sum of all written words
//                     is kept and the trailer must equal it; otherwise the
//                     trailer value is ignored.
//
// Ports:
//   clk           system clock
//   rstb          asynchronous active-low reset
//   rx_valid      one-cycle pulse, rx_data holds a new SPI word
//   rx_data       received word
//   ss_in         SPI slave select (active low); high = transaction ended
//   ram_we        RAM write strobe (one cycle per written word)
//   ram_addr      RAM write address
//   ram_wdata     RAM write data
//   subsurf_start one-cycle start pulse to the subdivision core
//   subsurf_busy  subdivision core running
//   busy          load or subdivision in progress
//   load_done     object processed, held until the next object starts
//   err           protocol or size error, held until ss_in goes high
//   vertex_count  latched V
//   face_count    latched F
// -----------------------------------------------------------------------------
module mesh_load_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  ss_in,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  subsurf_start,
    input  logic                  subsurf_busy,
    output logic                  busy,
    output logic                  load_done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] vertex_count,
    output logic [DATA_WIDTH-1:0] face_count
);

    // Size arithmetic is wide enough that 3*(V+F)+2 can never wrap.
    localparam int SZ_W = DATA_WIDTH + 3;
    localparam logic [SZ_W-1:0]       NUM_WORDS_C = {{(SZ_W-1){1'b0}}, 1'b1} << ADDR_WIDTH;
    localparam logic [SZ_W-1:0]       SZ_TWO_C    = {{(SZ_W-2){1'b0}}, 2'b10};
    localparam logic [DATA_WIDTH-1:0] D_ZERO_C    = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] D_ONE_C     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] A_ZERO_C    = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE_C     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_VERTS  = 4'd1,
        ST_FCOUNT = 4'd2,
        ST_FACES  = 4'd3,
        ST_TERM   = 4'd4,
        ST_START  = 4'd5,
        ST_RUN    = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [1:0]              sub_r;
    logic [1:0]              sub_nxt_s;
    logic [DATA_WIDTH-1:0]   elem_r;
    logic [DATA_WIDTH-1:0]   elem_nxt_s;
    logic                    wr_s;        // current word is written to RAM
    logic                    first_s;     // current word is a vertex count
    logic                    latch_f_s;   // current word is a face count
    logic [SZ_W-1:0]         v_size_s;
    logic [DATA_WIDTH:0]     vf_sum_s;
    logic [SZ_W-1:0]         total_s;
    logic [DATA_WIDTH-1:0]   count_lim_s;
    logic                    last_elem_s;
`ifdef MESH_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum_r;
`endif

    // Busy covers everything from the first vertex word to core completion.
    function automatic logic busy_of(input state_t s);
        case (s)
            ST_VERTS, ST_FCOUNT, ST_FACES, ST_TERM, ST_START, ST_RUN: busy_of = 1'b1;
            default:                                                  busy_of = 1'b0;
        endcase
    endfunction

    // 3*V+2 for an incoming vertex count, by shift-and-add.
    assign v_size_s = ({3'b000, rx_data} << 1) + {3'b000, rx_data} + SZ_TWO_C;
    // 3*(V+F)+2 for an incoming face count against the latched V.
    assign vf_sum_s = {1'b0, vertex_count} + {1'b0, rx_data};
    assign total_s  = ({2'b00, vf_sum_s} << 1) + {2'b00, vf_sum_s} + SZ_TWO_C;

    // Triplet element limit depends on which section is being received.
    assign count_lim_s = (state_r == ST_FACES) ? face_count : vertex_count;
    assign last_elem_s = (elem_r == (count_lim_s - D_ONE_C));

    // Next-state and per-word control decode.
    always_comb begin
        state_nxt_s = state_r;
        wr_s        = 1'b0;
        first_s     = 1'b0;
        latch_f_s   = 1'b0;
        sub_nxt_s   = sub_r;
        elem_nxt_s  = elem_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (rx_valid) begin
                    wr_s       = 1'b1;
                    first_s    = 1'b1;
                    sub_nxt_s  = 2'd0;
                    elem_nxt_s = D_ZERO_C;
                    if ((rx_data == D_ZERO_C) || (v_size_s > NUM_WORDS_C)) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        state_nxt_s = ST_VERTS;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_VERTS, ST_FACES: begin
                if (ss_in) begin
                    // Slave select released mid-object, also wins over a word.
                    state_nxt_s = ST_ERROR;
                end else if (rx_valid) begin
                    wr_s = 1'b1;
                    if (sub_r == 2'd2) begin
                        sub_nxt_s = 2'd0;
                        if (last_elem_s) begin
                            elem_nxt_s  = D_ZERO_C;
                            state_nxt_s = (state_r == ST_VERTS) ? ST_FCOUNT : ST_TERM;
                        end else begin
                            elem_nxt_s = elem_r + D_ONE_C;
                        end
                    end else begin
                        sub_nxt_s = sub_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FCOUNT: begin
                if (ss_in) begin
                    state_nxt_s = ST_ERROR;
                end else if (rx_valid) begin
                    wr_s      = 1'b1;
                    latch_f_s = 1'b1;
                    if ((rx_data == D_ZERO_C) || (total_s > NUM_WORDS_C)) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        state_nxt_s = ST_FACES;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_TERM: begin
                if (ss_in) begin
                    state_nxt_s = ST_ERROR;
                end else if (rx_valid) begin
`ifdef MESH_CHECKSUM_EN
                    if (rx_data != sum_r) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        state_nxt_s = ST_START;
                    end
`else
                    state_nxt_s = ST_START;
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_START: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (!subsurf_busy) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ERROR: begin
                if (ss_in) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, sequencing counters, RAM write port and registered status outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r       <= ST_IDLE;
            idx_r         <= A_ZERO_C;
            sub_r         <= 2'd0;
            elem_r        <= D_ZERO_C;
            ram_we        <= 1'b0;
            ram_addr      <= A_ZERO_C;
            ram_wdata     <= D_ZERO_C;
            subsurf_start <= 1'b0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            err           <= 1'b0;
            vertex_count  <= D_ZERO_C;
            face_count    <= D_ZERO_C;
`ifdef MESH_CHECKSUM_EN
            sum_r         <= D_ZERO_C;
`endif
        end else begin
            state_r       <= state_nxt_s;
            sub_r         <= sub_nxt_s;
            elem_r        <= elem_nxt_s;
            busy          <= busy_of(state_nxt_s);
            err           <= (state_nxt_s == ST_ERROR);
            load_done     <= (state_nxt_s == ST_DONE);
            subsurf_start <= (state_nxt_s == ST_START);
            ram_we        <= wr_s;
            if (wr_s) begin
                ram_wdata <= rx_data;
                if (first_s) begin
                    // Vertex count always lands at address 0.
                    ram_addr <= A_ZERO_C;
                    idx_r    <= A_ONE_C;
                end else begin
                    ram_addr <= idx_r;
                    idx_r    <= idx_r + A_ONE_C;
                end
            end
            if (first_s) begin
                vertex_count <= rx_data;
                face_count   <= D_ZERO_C;
            end else if (latch_f_s) begin
                face_count <= rx_data;
            end
`ifdef MESH_CHECKSUM_EN
            if (first_s) begin
                sum_r <= rx_data;
            end else if (wr_s) begin
                sum_r <= sum_r + rx_data;
            end
`endif
        end
    end

endmodule
